// File: rtl/register_write_sequencer.sv
// Write sequencer for a NAND-latch register bank: drives a shared DIN bus and a
// glitch-free one-hot strobe with DIN setup and hold around the strobe.
module register_write_sequencer #(
  parameter int  NUM_REGS      = 8,
  parameter int  SETUP_CYCLES  = 1,
  parameter int  STROBE_CYCLES = 1,
  parameter int  HOLD_CYCLES   = 1,
  localparam int ADDR_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                CLK,
  input  logic                notRESET,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic [ADDR_W-1:0]   REQ_ADDR,
  input  logic [15:0]         REQ_DATA,
  output logic [15:0]         REG_DIN,
  output logic [NUM_REGS-1:0] REG_W,
  output logic                DONE,
  output logic                ERR
);

  localparam int MAX_CYC = (SETUP_CYCLES > STROBE_CYCLES)
                         ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                         : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [ADDR_W:0]  NUM_REGS_W  = NUM_REGS[ADDR_W:0];

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_REGS-1:0] r_mask;
  logic                r_oor;
  logic                r_ready;
  logic [15:0]         r_din;
  logic [NUM_REGS-1:0] r_reg_w;
  logic                r_done;
  logic                r_err;

  logic [1:0]          w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_accept;
  logic                w_req_in_range;
  logic [NUM_REGS-1:0] w_req_mask;

  // The strobe pattern is decoded at capture time so REG_W is a plain copy of a flop.
  assign w_req_in_range = {1'b0, REQ_ADDR} < NUM_REGS_W;
  assign w_req_mask     = w_req_in_range ? (NUM_REGS'(1) << REQ_ADDR) : '0;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (REQ_VALID && r_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = SETUP_LOAD;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = STROBE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so each one is a bare flop.
  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_oor   <= 1'b0;
      r_ready <= 1'b1;
      r_din   <= 16'h0000;
      r_reg_w <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_din  <= REQ_DATA;
        r_mask <= w_req_mask;
        r_oor  <= ~w_req_in_range;
      end
      r_ready <= (w_state_nxt == S_IDLE);
      r_reg_w <= (w_state_nxt == S_STROBE) ? r_mask : '0;
      r_done  <= (w_state_nxt == S_HOLD) && (w_cnt_nxt == '0);
      r_err   <= (w_state_nxt == S_HOLD) && (w_cnt_nxt == '0) && r_oor;
    end
  end

  assign REQ_READY = r_ready;
  assign REG_DIN   = r_din;
  assign REG_W     = r_reg_w;
  assign DONE      = r_done;
  assign ERR       = r_err;

endmodule

// File: tb/tb_register_write_sequencer.sv
// Randomised bench for register_write_sequencer: three parameterisations run side by
// side, each checked every cycle against a timing model derived from acceptance offset.
`timescale 1ns/1ps
module tb_register_write_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NR = (g == 1) ? 6 : 8;
    localparam int S  = (g == 2) ? 2 : 1;
    localparam int T  = (g == 2) ? 3 : 1;
    localparam int H  = (g == 2) ? 2 : 1;

    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_addr;
    logic [15:0]   req_data;
    logic [15:0]   reg_din;
    logic [NR-1:0] reg_w;
    logic          done;
    logic          err;
    logic          bank_clr;
    logic          fin_g = 1'b0;

    register_write_sequencer #(
      .NUM_REGS(NR), .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)
    ) u_dut (
      .CLK(clk), .notRESET(rst_n), .REQ_VALID(req_valid), .REQ_READY(req_ready),
      .REQ_ADDR(req_addr), .REQ_DATA(req_data), .REG_DIN(reg_din), .REG_W(reg_w),
      .DONE(done), .ERR(err)
    );

    // Behavioural NAND-latch bank: transparent while its strobe bit is high.
    logic [15:0] bank [NR];
    always @(reg_w or reg_din or bank_clr or rst_n) begin
      for (int i = 0; i < NR; i++) begin
        if (bank_clr) bank[i] = 16'h0000;
        else if (rst_n && reg_w[i]) bank[i] = reg_din;
      end
    end

    // Reference model: a request accepted at edge k is described purely by d = edges since k.
    bit          m_busy;
    int          m_d;
    int          m_addr;
    logic [15:0] m_data;
    logic [15:0] m_din;
    logic [15:0] exp_bank [NR];
    int          cyc;
    int          last_acc;
    bit          iv_on;

    task automatic compare();
      logic [NR-1:0] ew;
      bit            strobe;
      bit            edone;
      ew     = '0;
      strobe = m_busy && (m_d >= S) && (m_d < S + T);
      if (strobe && m_addr < NR) begin
        ew[m_addr]       = 1'b1;
        exp_bank[m_addr] = m_data;
      end
      edone = m_busy && (m_d == S + T + H - 1);
      check($sformatf("u%0d ready", g), 32'(req_ready), 32'(!m_busy));
      check($sformatf("u%0d din", g), 32'(reg_din), 32'(m_din));
      check($sformatf("u%0d w", g), 32'(reg_w), 32'(ew));
      check($sformatf("u%0d done", g), 32'(done), 32'(edone));
      check($sformatf("u%0d err", g), 32'(err), 32'(edone && m_addr >= NR));
    endtask

    task automatic tick();
      if (iv_on && rst_n && req_valid && req_ready) begin
        if (last_acc >= 0)
          check($sformatf("u%0d accept_interval", g), 32'(cyc + 1 - last_acc), 32'(1 + S + T + H));
        last_acc = cyc + 1;
      end
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 1'b0;
        m_din  = 16'h0000;
      end else if (m_busy) begin
        m_d++;
        if (m_d == S + T + H) m_busy = 1'b0;
      end else if (req_valid) begin
        m_busy = 1'b1;
        m_d    = 0;
        m_addr = int'(req_addr);
        m_data = req_data;
        m_din  = req_data;
      end
      @(negedge clk);
      compare();
    endtask

    task automatic check_reset_state(input string sfx);
      check($sformatf("u%0d %s ready", g, sfx), 32'(req_ready), 32'd1);
      check($sformatf("u%0d %s din", g, sfx), 32'(reg_din), 32'h0000);
      check($sformatf("u%0d %s w", g, sfx), 32'(reg_w), 32'd0);
      check($sformatf("u%0d %s done", g, sfx), 32'(done), 32'd0);
      check($sformatf("u%0d %s err", g, sfx), 32'(err), 32'd0);
    endtask

    initial begin
      int guard;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      bank_clr  = 1'b1;
      m_busy    = 1'b0;
      m_d       = 0;
      m_addr    = 0;
      m_data    = '0;
      m_din     = '0;
      cyc       = 0;
      last_acc  = -1;
      iv_on     = 1'b0;
      for (int i = 0; i < NR; i++) exp_bank[i] = 16'h0000;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      bank_clr = 1'b0;
      rst_n    = 1'b1;

      // Single write, then model-checked idle cycles.
      req_valid = 1'b1; req_addr = 3'd3; req_data = 16'hAAAA;
      tick();
      req_valid = 1'b0;
      repeat (S + T + H + 3) tick();
      check($sformatf("u%0d single_reg3", g), 32'(bank[3]), 32'hAAAA);

      // Request inputs change after acceptance and must be ignored.
      req_valid = 1'b1; req_addr = 3'd5; req_data = 16'hAAAA;
      tick();
      req_valid = 1'b0; req_addr = 3'd1; req_data = 16'h0000;
      repeat (S + T + H + 2) tick();
      check($sformatf("u%0d mutate_reg5", g), 32'(bank[5]), 32'hAAAA);
      check($sformatf("u%0d mutate_reg1", g), 32'(bank[1]), 32'h0000);

      // Sweep every index, including out-of-range ones on the 6-register instance.
      for (int i = 0; i < 8; i++) begin
        req_valid = 1'b1; req_addr = 3'(i); req_data = 16'(i * 16'h1111);
        tick();
        req_valid = 1'b0;
        repeat (S + T + H) tick();
      end
      repeat (2) tick();
      for (int i = 0; i < NR; i++)
        check($sformatf("u%0d sweep_reg%0d", g, i), 32'(bank[i]), 32'(i * 16'h1111));

      // REQ_VALID held high: acceptance spacing is the full sequence length.
      iv_on = 1'b1; last_acc = -1;
      req_valid = 1'b1;
      repeat (40) begin
        req_addr = 3'($urandom_range(0, 7));
        req_data = 16'($urandom);
        tick();
      end
      req_valid = 1'b0; iv_on = 1'b0;
      repeat (S + T + H + 2) tick();

      // Random traffic with inputs churning throughout.
      repeat (150) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_addr  = 3'($urandom_range(0, 7));
        req_data  = 16'($urandom);
        tick();
      end
      req_valid = 1'b0;
      repeat (S + T + H + 2) tick();

      // Asynchronous reset while the strobe is high.
      req_valid = 1'b1; req_addr = 3'd2; req_data = 16'h5A5A;
      tick();
      req_valid = 1'b0;
      guard = 0;
      while (!(m_busy && m_d >= S) && guard < 20) begin
        tick();
        guard++;
      end
      check($sformatf("u%0d strobe_before_reset", g), 32'(reg_w[2]), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_state("midreset");
      m_busy = 1'b0;
      m_din  = 16'h0000;
      tick();
      rst_n = 1'b1;
      repeat (S + T + H + 2) tick();

      for (int i = 0; i < NR; i++)
        check($sformatf("u%0d final_reg%0d", g, i), 32'(bank[i]), 32'(exp_bank[i]));
      fin_g = 1'b1;
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (!(g_dut[0].fin_g && g_dut[1].fin_g && g_dut[2].fin_g) && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    check("all_instances_finished",
          32'(g_dut[0].fin_g && g_dut[1].fin_g && g_dut[2].fin_g), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
